bounce_box_gen: RTL and testbench

//   Animated pixel source between vga640x480 and the RGB pins: consumes the raw h/v scan counters and returns

---
 rtl/bounce_box_if.sv | 14 +
 rtl/bounce_box_gen.sv | 103 ++++++++++
 tb/tb_bounce_box_gen.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/bounce_box_if.sv
// Scan-counter / pixel bundle between the VGA timing block and the box generator.
// The timing side drives h, v and run; the generator returns colour and the bounce strobe.
interface bounce_box_if;
    logic       run;
    logic [9:0] h;
    logic [9:0] v;
    logic [2:0] red;
    logic [2:0] green;
    logic [1:0] blue;
    logic       hit;

    modport master (output run, h, v, input red, green, blue, hit);
    modport slave  (input run, h, v, output red, green, blue, hit);
endinterface

// File: rtl/bounce_box_gen.sv
// Bouncing-box pixel source: registered 3-3-2 colour one dclk after h/v.
// The box position steps once per frame on the line after the visible area.
module bounce_box_gen #(
    parameter int          HBP   = 144,
    parameter int          HFP   = 784,
    parameter int          VBP   = 31,
    parameter int          VFP   = 511,
    parameter int          BOX_W = 32,
    parameter int          BOX_H = 32,
    parameter int          STEP  = 2,
    parameter logic [7:0]  BG    = 8'b010_010_01
) (
    input  logic          dclk,
    input  logic          clr,
    bounce_box_if.slave   bus
);

    localparam logic [10:0] X_MAX = 11'(640 - BOX_W);
    localparam logic [10:0] Y_MAX = 11'(480 - BOX_H);

    logic [9:0] bx_q, bx_d, by_q, by_d;
    logic       dx_neg_q, dx_neg_d, dy_neg_q, dy_neg_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic [7:0] rgb_q, rgb_d;
    logic       hit_q, hit_d;

    logic [9:0] px, py;
    logic       vis, in_box, upd;
    logic [7:0] box_col;
    logic [11:0] x_nxt, y_nxt;

    // Returns {bounce, negative_dir, new_pos}; the 11-bit sum cannot wrap.
    function automatic logic [11:0] axis_step(input logic [9:0] pos, input logic neg,
                                              input logic [10:0] lim);
        logic [10:0] sum;
        sum = {1'b0, pos} + 11'(STEP);
        if (!neg) begin
            if (sum >= lim) return {1'b1, 1'b1, lim[9:0]};
            return {1'b0, 1'b0, sum[9:0]};
        end
        if ({1'b0, pos} <= 11'(STEP)) return {1'b1, 1'b0, 10'd0};
        return {1'b0, 1'b1, pos - 10'(STEP)};
    endfunction

    always_comb begin
        px      = bus.h - 10'(HBP);
        py      = bus.v - 10'(VBP);
        vis     = (bus.h >= 10'(HBP)) && (bus.h < 10'(HFP)) &&
                  (bus.v >= 10'(VBP)) && (bus.v < 10'(VFP));
        in_box  = ({1'b0, px} >= {1'b0, bx_q}) && ({1'b0, px} < {1'b0, bx_q} + 11'(BOX_W)) &&
                  ({1'b0, py} >= {1'b0, by_q}) && ({1'b0, py} < {1'b0, by_q} + 11'(BOX_H));
        box_col = {frame_cnt_q[7:5], ~frame_cnt_q[7:5], frame_cnt_q[6:5]};
        if (!vis)        rgb_d = 8'h00;
        else if (in_box) rgb_d = box_col;
        else             rgb_d = BG;
    end

    always_comb begin
        upd         = (bus.h == 10'd0) && (bus.v == 10'(VFP));
        x_nxt       = axis_step(bx_q, dx_neg_q, X_MAX);
        y_nxt       = axis_step(by_q, dy_neg_q, Y_MAX);
        bx_d        = bx_q;
        by_d        = by_q;
        dx_neg_d    = dx_neg_q;
        dy_neg_d    = dy_neg_q;
        frame_cnt_d = frame_cnt_q;
        hit_d       = 1'b0;
        if (upd) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
            if (bus.run) begin
                {dx_neg_d, bx_d} = x_nxt[10:0];
                {dy_neg_d, by_d} = y_nxt[10:0];
                hit_d            = x_nxt[11] | y_nxt[11];
            end
        end
    end

    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            bx_q        <= '0;
            by_q        <= '0;
            dx_neg_q    <= 1'b0;
            dy_neg_q    <= 1'b0;
            frame_cnt_q <= '0;
            rgb_q       <= '0;
            hit_q       <= 1'b0;
        end else begin
            bx_q        <= bx_d;
            by_q        <= by_d;
            dx_neg_q    <= dx_neg_d;
            dy_neg_q    <= dy_neg_d;
            frame_cnt_q <= frame_cnt_d;
            rgb_q       <= rgb_d;
            hit_q       <= hit_d;
        end
    end

    assign bus.red   = rgb_q[7:5];
    assign bus.green = rgb_q[4:2];
    assign bus.blue  = rgb_q[1:0];
    assign bus.hit   = hit_q;

endmodule

// File: tb/tb_bounce_box_gen.sv
// Directed bench: drives h/v straight to pixel and update points; a second
// instance with a 192-wide box makes both axes bounce on the same frame.
module tb_bounce_box_gen;

    localparam int HBP = 144;
    localparam int VBP = 31;
    localparam int VFP = 511;
    localparam logic [7:0] BG  = 8'b010_010_01;
    localparam logic [7:0] C0  = 8'b000_111_00;
    localparam logic [7:0] C1  = 8'b001_110_01;
    localparam logic [7:0] C7  = 8'b111_000_11;

    logic dclk = 1'b0;
    logic clr  = 1'b1;
    logic run  = 1'b1;
    logic [9:0] h = '0;
    logic [9:0] v = '0;

    bounce_box_if ifa ();
    bounce_box_if ifb ();

    assign ifa.h = h;  assign ifa.v = v;  assign ifa.run = run;
    assign ifb.h = h;  assign ifb.v = v;  assign ifb.run = run;

    bounce_box_gen u_a (.dclk(dclk), .clr(clr), .bus(ifa));
    bounce_box_gen #(.BOX_W(192)) u_b (.dclk(dclk), .clr(clr), .bus(ifb));

    logic [7:0] rgb_a, rgb_b;
    assign rgb_a = {ifa.red, ifa.green, ifa.blue};
    assign rgb_b = {ifb.red, ifb.green, ifb.blue};

    always #20 dclk = ~dclk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic tick(input int hh, input int vv);
        h = 10'(hh);
        v = 10'(vv);
        @(posedge dclk);
        #1;
    endtask

    task automatic pix(input int x, input int y, input logic [7:0] e, input string tag);
        tick(HBP + x, VBP + y);
        chk(tag, 32'(rgb_a), 32'(e));
    endtask

    task automatic upd(input logic ea, input logic eb, input string tag);
        tick(0, VFP);
        chk(tag, 32'(ifa.hit), 32'(ea));
        chk({tag, "_b"}, 32'(ifb.hit), 32'(eb));
    endtask

    initial begin
        #50;
        chk("rst_rgb", 32'(rgb_a), 0);
        chk("rst_hit", 32'(ifa.hit), 0);
        clr = 1'b0;

        // frame 0: box at (0,0), colour for frame_cnt 0
        tick(100, 100);
        chk("blank", 32'(rgb_a), 0);
        h = 10'(HBP); v = 10'(VBP);
        #5;
        chk("latency", 32'(rgb_a), 0);
        @(posedge dclk); #1;
        chk("px00", 32'(rgb_a), 32'(C0));
        pix(31, 31, C0, "px31_31");
        pix(32, 0, BG, "px32_0");
        pix(0, 32, BG, "px0_32");
        pix(639, 479, BG, "px_last");
        tick(1000, 100);
        chk("h_oob", 32'(rgb_a), 0);

        for (int f = 1; f <= 10; f++) upd(1'b0, 1'b0, "hit_f10");
        pix(20, 20, C0, "f10_in");
        pix(52, 20, BG, "f10_x52");
        pix(19, 20, BG, "f10_x19");
        pix(20, 51, C0, "f10_y51");
        pix(20, 52, BG, "f10_y52");
        pix(51, 51, C0, "f10_corner");

        for (int f = 11; f <= 223; f++) begin
            upd(1'b0, 1'b0, "hit_run");
            if (f == 31) pix(62, 62, C0, "col_f31");
            if (f == 32) pix(64, 64, C1, "col_f32");
        end

        // U#224: A bounces in y only, B in both axes with a single pulse
        upd(1'b1, 1'b1, "hit_224");
        tick(100, 100);
        chk("hit_224_once", 32'(ifa.hit), 0);
        chk("hit_224_once_b", 32'(ifb.hit), 0);
        pix(448, 448, C7, "f224_in");
        pix(447, 448, BG, "f224_x447");
        tick(HBP + 639, VBP + 479);
        chk("f224_a_corner", 32'(rgb_a), 32'(BG));
        chk("f224_b_corner", 32'(rgb_b), 32'(C7));
        tick(HBP + 447, VBP + 479);
        chk("f224_b_x447", 32'(rgb_b), 32'(BG));

        upd(1'b0, 1'b0, "hit_225");
        pix(450, 446, C7, "f225_in");
        pix(449, 446, BG, "f225_x449");
        pix(450, 445, BG, "f225_y445");
        pix(481, 477, C7, "f225_far");
        pix(482, 477, BG, "f225_x482");

        for (int f = 226; f <= 303; f++) upd(1'b0, 1'b0, "hit_run2");
        pix(606, 290, C1, "f303_in");
        upd(1'b1, 1'b0, "hit_304");
        tick(100, 100);
        chk("hit_304_once", 32'(ifa.hit), 0);
        pix(608, 288, C1, "f304_in");
        pix(607, 288, BG, "f304_x607");
        pix(639, 319, C1, "f304_far");
        upd(1'b0, 1'b0, "hit_305");
        pix(606, 286, C1, "f305_in");
        pix(605, 286, BG, "f305_x605");

        run = 1'b0;
        for (int f = 306; f <= 310; f++) upd(1'b0, 1'b0, "hit_hold");
        pix(606, 286, C1, "hold_in");
        pix(605, 286, BG, "hold_x605");
        pix(606, 285, BG, "hold_y285");
        run = 1'b1;
        upd(1'b0, 1'b0, "hit_311");
        pix(604, 284, C1, "f311_in");
        pix(603, 284, BG, "f311_x603");

        // mid-frame async reset
        pix(400 - HBP, 200 - VBP, BG, "pre_clr");
        pix(604, 284, C1, "pre_clr_box");
        tick(400, 200);
        clr = 1'b1;
        #1;
        chk("clr_rgb", 32'(rgb_a), 0);
        chk("clr_hit", 32'(ifa.hit), 0);
        repeat (3) @(posedge dclk);
        #1;
        chk("clr_hold", 32'(rgb_a), 0);
        clr = 1'b0;
        pix(0, 0, C0, "post_px00");
        pix(32, 0, BG, "post_px32");
        pix(604, 284, BG, "post_old");
        upd(1'b0, 1'b0, "post_u1");
        pix(2, 2, C0, "post_f1_in");
        pix(1, 2, BG, "post_f1_x1");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
